// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
//   ped_state_t : the six phases of the road/crosswalk cycle
//   LIGHT_*     : one-hot {R,Y,G} light encodings
//   max_of      : helper used to size the phase timer
package ped_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_ROAD_GREEN  = 3'd0,
      ST_ROAD_YELLOW = 3'd1,
      ST_ALL_RED1    = 3'd2,
      ST_WALK        = 3'd3,
      ST_PED_CLEAR   = 3'd4,
      ST_ALL_RED2    = 3'd5
   } ped_state_t;

   localparam logic [2:0] LIGHT_R   = 3'b100;
   localparam logic [2:0] LIGHT_Y   = 3'b010;
   localparam logic [2:0] LIGHT_G   = 3'b001;
   localparam logic [2:0] LIGHT_OFF = 3'b000;

   function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/req_edge_cnt.sv
// Pedestrian request edge detector and saturating request counter.
//   clk, rst  : clock, synchronous active-high reset
//   req       : synchronised button levels
//   count_a   : registered count of accepted rising edges, saturates at 2**CNT_W-1
//   any_rise  : combinational, high when any button rose this cycle
module req_edge_cnt #(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [CNT_W-1:0] count_a,
   output logic             any_rise
);

   // Wide enough to hold count plus a full popcount without overflow.
   localparam int unsigned SUM_W = CNT_W + $clog2(N_REQ + 1);
   localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

   logic [N_REQ-1:0] req_q;
   logic [N_REQ-1:0] rise;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] count_d;

   // Edge detect, popcount and saturating add.
   always_comb begin
      rise     = req & ~req_q;
      any_rise = |rise;
      sum      = SUM_W'(count_a);
      for (int i = 0; i < int'(N_REQ); i++) begin
         sum = sum + SUM_W'(rise[i]);
      end
      count_d = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         count_a <= '0;
      end else begin
         req_q   <= req;
         count_a <= count_d;
      end
   end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Road / pedestrian crossing controller. Latches button requests, counts them
// and sequences road and crosswalk lights through a fixed phase cycle.
//   clk, rst        : clock, synchronous active-high reset
//   tick            : timebase enable for the phase timer
//   req             : pedestrian buttons (level, synchronised)
//   count_a         : accepted-request count, saturating
//   road_light      : one-hot {R,Y,G}, registered
//   crosswalk_light : one-hot {R,Y,G}, registered
// Build option PED_CTRL_FLASH_EN: crosswalk flashes green/off during PED_CLEAR
// instead of showing steady yellow.
module ped_crossing_ctrl
   import ped_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ     = 3,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned MIN_GREEN = 4,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned WALK_T    = 5,
   parameter int unsigned CLEAR_T   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [N_REQ-1:0] req,
   output logic [CNT_W-1:0] count_a,
   output logic [2:0]       road_light,
   output logic [2:0]       crosswalk_light
);

   localparam int unsigned MAX_DUR = max_of(max_of(max_of(MIN_GREEN, YELLOW_T),
                                                   max_of(ALLRED_T, WALK_T)), CLEAR_T);
   localparam int unsigned TMR_W   = $clog2(MAX_DUR + 1);

   ped_state_t       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             pending_q, pending_d;
   logic [2:0]       road_d, cw_d;
   logic             any_rise;
`ifdef PED_CTRL_FLASH_EN
   logic             flash_q, flash_d;
`endif

   req_edge_cnt #(
      .N_REQ (N_REQ),
      .CNT_W (CNT_W)
   ) u_req_edge_cnt (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .count_a  (count_a),
      .any_rise (any_rise)
   );

   // State, timer, pending flag and registered lights.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_ROAD_GREEN;
         timer_q         <= TMR_W'(MIN_GREEN - 1);
         pending_q       <= 1'b0;
         road_light      <= LIGHT_G;
         crosswalk_light <= LIGHT_R;
`ifdef PED_CTRL_FLASH_EN
         flash_q         <= 1'b1;
`endif
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         pending_q       <= pending_d;
         road_light      <= road_d;
         crosswalk_light <= cw_d;
`ifdef PED_CTRL_FLASH_EN
         flash_q         <= flash_d;
`endif
      end
   end

   // Next state, timer reload, pending flag and light decode of the next state.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      pending_d = pending_q;
      road_d    = LIGHT_R;
      cw_d      = LIGHT_R;

      if (tick && (timer_q != '0)) begin
         timer_d = timer_q - TMR_W'(1);
      end

      // Exits only happen with timer at zero, so the reload below never
      // collides with the decrement above.
      case (state_q)
         ST_ROAD_GREEN: begin
            if (tick && (timer_q == '0) && pending_q) begin
               state_d = ST_ROAD_YELLOW;
               timer_d = TMR_W'(YELLOW_T - 1);
            end
         end
         ST_ROAD_YELLOW: begin
            if (tick && (timer_q == '0)) begin
               state_d = ST_ALL_RED1;
               timer_d = TMR_W'(ALLRED_T - 1);
            end
         end
         ST_ALL_RED1: begin
            if (tick && (timer_q == '0)) begin
               state_d = ST_WALK;
               timer_d = TMR_W'(WALK_T - 1);
            end
         end
         ST_WALK: begin
            if (tick && (timer_q == '0)) begin
               state_d = ST_PED_CLEAR;
               timer_d = TMR_W'(CLEAR_T - 1);
            end
         end
         ST_PED_CLEAR: begin
            if (tick && (timer_q == '0)) begin
               state_d = ST_ALL_RED2;
               timer_d = TMR_W'(ALLRED_T - 1);
            end
         end
         ST_ALL_RED2: begin
            if (tick && (timer_q == '0)) begin
               state_d = ST_ROAD_GREEN;
               timer_d = TMR_W'(MIN_GREEN - 1);
            end
         end
         default: begin
            state_d = ST_ROAD_GREEN;
            timer_d = TMR_W'(MIN_GREEN - 1);
         end
      endcase

      // Edges during WALK are counted but not latched; entering WALK clears
      // the flag and takes priority over a same-cycle set.
      if (any_rise && (state_q != ST_WALK)) begin
         pending_d = 1'b1;
      end
      if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
         pending_d = 1'b0;
      end

`ifdef PED_CTRL_FLASH_EN
      flash_d = flash_q;
      if ((state_d == ST_PED_CLEAR) && (state_q != ST_PED_CLEAR)) begin
         flash_d = 1'b1;
      end else if ((state_q == ST_PED_CLEAR) && tick) begin
         flash_d = ~flash_q;
      end
`endif

      case (state_d)
         ST_ROAD_GREEN:  road_d = LIGHT_G;
         ST_ROAD_YELLOW: road_d = LIGHT_Y;
         ST_WALK:        cw_d   = LIGHT_G;
         ST_PED_CLEAR: begin
`ifdef PED_CTRL_FLASH_EN
            cw_d = flash_d ? LIGHT_G : LIGHT_OFF;
`else
            cw_d = LIGHT_Y;
`endif
         end
         default: begin
            road_d = LIGHT_R;
            cw_d   = LIGHT_R;
         end
      endcase
   end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: table-driven reset/sequence vectors, directed
// corner-case sequences and randomized traffic against a phase-table model.
module tb_ped_crossing_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [2:0] req = 3'b000;
   logic [3:0] count_a;
   logic [2:0] road_light;
   logic [2:0] crosswalk_light;

   always #5 clk = ~clk;

   ped_crossing_ctrl #(
      .N_REQ(3), .CNT_W(4), .MIN_GREEN(4), .YELLOW_T(2),
      .ALLRED_T(1), .WALK_T(5), .CLEAR_T(3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tick            (tick),
      .req             (req),
      .count_a         (count_a),
      .road_light      (road_light),
      .crosswalk_light (crosswalk_light)
   );

`ifdef PED_CTRL_FLASH_EN
   localparam logic [2:0] CLR_A = 3'b001;
   localparam logic [2:0] CLR_B = 3'b000;
`else
   localparam logic [2:0] CLR_A = 3'b010;
   localparam logic [2:0] CLR_B = 3'b010;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Model: phase index into a duration table, ticks elapsed in phase.
   int         dur [6] = '{4, 2, 1, 5, 3, 1};
   int         m_phase = 0;
   int         m_el = 0;
   int         m_cnt = 0;
   bit         m_pend = 0;
   bit         m_flash = 1;
   logic [2:0] m_reqq = 3'b000;

   int         walk_entries = 0;
   logic [2:0] prev_road, prev_cw;

   typedef struct {
      logic       r;
      logic       t;
      logic [2:0] q;
      logic [2:0] road;
      logic [2:0] cw;
      logic [3:0] cnt;
   } vec_t;

   vec_t vt[$];

   function automatic logic [2:0] m_road();
      case (m_phase)
         0:       return 3'b001;
         1:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] m_cw();
      case (m_phase)
         3: return 3'b001;
`ifdef PED_CTRL_FLASH_EN
         4: return m_flash ? 3'b001 : 3'b000;
`else
         4: return 3'b010;
`endif
         default: return 3'b100;
      endcase
   endfunction

   task automatic model_clk(input logic r, input logic t, input logic [2:0] q);
      logic [2:0] rise;
      bit         new_pend;
      bit         entered_walk;
      if (r) begin
         m_phase = 0; m_el = 0; m_cnt = 0; m_pend = 0; m_flash = 1; m_reqq = 3'b000;
      end else begin
         rise   = q & ~m_reqq;
         m_reqq = q;
         m_cnt  = m_cnt + $countones(rise);
         if (m_cnt > 15) m_cnt = 15;
         new_pend     = m_pend || ((rise != 3'b000) && (m_phase != 3));
         entered_walk = 0;
         if (t) begin
            if ((m_el + 1 >= dur[m_phase]) && ((m_phase != 0) || m_pend)) begin
               m_phase      = (m_phase + 1) % 6;
               m_el         = 0;
               m_flash      = 1;
               entered_walk = (m_phase == 3);
            end else begin
               if (m_el + 1 < dur[m_phase]) m_el++;
               if (m_phase == 4) m_flash = !m_flash;
            end
         end
         if (entered_walk) new_pend = 0;
         m_pend = new_pend;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, advance model, compare DUT against model.
   task automatic step(input logic r, input logic t, input logic [2:0] q);
      rst = r; tick = t; req = q;
      prev_road = road_light;
      prev_cw   = crosswalk_light;
      @(posedge clk);
      model_clk(r, t, q);
      #1;
      check("model_road", int'(road_light), int'(m_road()));
      check("model_cw", int'(crosswalk_light), int'(m_cw()));
      check("model_count", int'(count_a), m_cnt);
      if (!r && crosswalk_light == 3'b001 && prev_cw == 3'b100 && prev_road == 3'b100)
         walk_entries++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 3'b000);
      step(1'b1, 1'b1, 3'b000);
   endtask

   task automatic wait_for(input logic [2:0] rd, input logic [2:0] cw, input string nm);
      int n = 0;
      while (!(road_light == rd && crosswalk_light == cw) && n < 100) begin
         step(1'b0, 1'b1, 3'b000);
         n++;
      end
      check(nm, (n < 100) ? 1 : 0, 1);
   endtask

   function automatic vec_t mk(logic r, logic t, logic [2:0] q,
                               logic [2:0] rd, logic [2:0] cw, logic [3:0] c);
      vec_t v;
      v.r = r; v.t = t; v.q = q; v.road = rd; v.cw = cw; v.cnt = c;
      return v;
   endfunction

   initial begin
      // Reset, single request and the full phase sequence that follows.
      vt.push_back(mk(1, 1, 3'b000, 3'b001, 3'b100, 0));
      vt.push_back(mk(1, 1, 3'b000, 3'b001, 3'b100, 0));
      vt.push_back(mk(0, 1, 3'b001, 3'b001, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b001, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b001, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b010, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b010, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b100, 3'b100, 1));
      for (int i = 0; i < 5; i++) vt.push_back(mk(0, 1, 3'b000, 3'b100, 3'b001, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b100, CLR_A, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b100, CLR_B, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b100, CLR_A, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b100, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b001, 3'b100, 1));
      vt.push_back(mk(0, 1, 3'b000, 3'b001, 3'b100, 1));

      foreach (vt[i]) begin
         step(vt[i].r, vt[i].t, vt[i].q);
         check($sformatf("vec%0d_road", i), int'(road_light), int'(vt[i].road));
         check($sformatf("vec%0d_cw", i), int'(crosswalk_light), int'(vt[i].cw));
         check($sformatf("vec%0d_count", i), int'(count_a), int'(vt[i].cnt));
      end

      // No request: road stays green indefinitely.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 1'b1, 3'b000);
         check("idle_green", int'(road_light), 1);
      end

      // Simultaneous edges on all buttons: three counts, one WALK.
      do_reset();
      walk_entries = 0;
      step(1'b0, 1'b1, 3'b111);
      check("triple_count", int'(count_a), 3);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 3'b000);
      check("triple_one_walk", walk_entries, 1);

      // Saturation at 15.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 3'b010);
         step(1'b0, 1'b1, 3'b000);
      end
      check("sat_count", int'(count_a), 15);

      // Edge inside WALK is counted but does not cause a second WALK.
      do_reset();
      step(1'b0, 1'b1, 3'b001);
      step(1'b0, 1'b1, 3'b000);
      wait_for(3'b100, 3'b001, "reach_walk_a");
      walk_entries = 0;
      step(1'b0, 1'b1, 3'b010);
      check("walk_edge_count", int'(count_a), 2);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 3'b000);
      check("walk_edge_no_rewalk", walk_entries, 0);

      // Held button yields a single edge and a single WALK.
      do_reset();
      walk_entries = 0;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 3'b100);
      check("held_count", int'(count_a), 1);
      check("held_one_walk", walk_entries, 1);

      // tick low freezes lights mid-yellow.
      do_reset();
      step(1'b0, 1'b1, 3'b001);
      wait_for(3'b010, 3'b100, "reach_yellow");
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 3'b000);
         check("freeze_road", int'(road_light), 2);
      end
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'b000);

      // Reset during WALK discards the phase.
      do_reset();
      step(1'b0, 1'b1, 3'b001);
      wait_for(3'b100, 3'b001, "reach_walk_b");
      step(1'b1, 1'b1, 3'b000);
      check("rst_walk_road", int'(road_light), 1);
      check("rst_walk_cw", int'(crosswalk_light), 4);
      check("rst_walk_count", int'(count_a), 0);

      // Clearance light pattern (steady yellow or flashing green).
      step(1'b0, 1'b1, 3'b001);
      wait_for(3'b100, 3'b001, "reach_walk_c");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'b000);
      step(1'b0, 1'b1, 3'b000);
      check("clear_0", int'(crosswalk_light), int'(CLR_A));
      step(1'b0, 1'b0, 3'b000);
      check("clear_hold", int'(crosswalk_light), int'(CLR_A));
      step(1'b0, 1'b1, 3'b000);
      check("clear_1", int'(crosswalk_light), int'(CLR_B));
      step(1'b0, 1'b1, 3'b000);
      check("clear_2", int'(crosswalk_light), int'(CLR_A));
      step(1'b0, 1'b1, 3'b000);
      check("clear_exit", int'(crosswalk_light), 4);

      // Randomized traffic against the model.
      begin
         logic [2:0] qv = 3'b000;
         for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
               if ($urandom_range(0, 9) == 0) qv[b] = ~qv[b];
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), qv);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
